// File: rtl/aesl_deadlock_monitor_if.sv
// Handshake bundle between the deadlock monitor and the dataflow region it
// watches. The optional dl_timeout signal exists only when
// AESL_DEADLOCK_TIMEOUT_EN is defined.
interface aesl_deadlock_monitor_if #(
    parameter int NPROC = 4
);
    logic [NPROC-1:0]       proc_blocked;
    logic [NPROC*NPROC-1:0] dep_matrix;
    logic                   dl_clear;
    logic                   dl_detect;
    logic [NPROC-1:0]       dl_origin;
    logic [NPROC-1:0]       dl_path;
    logic                   busy;
`ifdef AESL_DEADLOCK_TIMEOUT_EN
    logic                   dl_timeout;

    modport master (
        output proc_blocked, dep_matrix, dl_clear,
        input  dl_detect, dl_origin, dl_path, busy, dl_timeout
    );
    modport slave (
        input  proc_blocked, dep_matrix, dl_clear,
        output dl_detect, dl_origin, dl_path, busy, dl_timeout
    );
`else
    modport master (
        output proc_blocked, dep_matrix, dl_clear,
        input  dl_detect, dl_origin, dl_path, busy
    );
    modport slave (
        input  proc_blocked, dep_matrix, dl_clear,
        output dl_detect, dl_origin, dl_path, busy
    );
`endif
endinterface

// File: rtl/aesl_deadlock_monitor.sv
// Dataflow deadlock monitor. Waits for the blocked/dependency snapshot to
// settle, then walks the wait-for graph one process per cycle looking for a
// cycle among blocked processes, and holds a report until acknowledged.
// Optional feature: define AESL_DEADLOCK_TIMEOUT_EN to add the dl_timeout
// blocked-too-long indicator.
module aesl_deadlock_monitor #(
    parameter int NPROC         = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input logic                    clock,
    input logic                    reset,
    aesl_deadlock_monitor_if.slave mon
);
    localparam int IW = $clog2(NPROC);
    localparam logic [NPROC-1:0] ONE = NPROC'(1);

    typedef enum logic [2:0] {IDLE, SETTLE, WALK, REPORT, HOLDOFF} state_t;

    state_t                 state, state_n;
    logic [NPROC-1:0]       snap_blk, snap_blk_n;
    logic [NPROC*NPROC-1:0] snap_dep, snap_dep_n;
    logic [7:0]             settle_cnt, settle_cnt_n;
    logic [IW-1:0]          origin, origin_n;
    logic [IW-1:0]          cur, cur_n;
    logic [NPROC-1:0]       visited, visited_n;
    logic                   det, det_n;
    logic [NPROC-1:0]       org_oh, org_oh_n;
    logic [NPROC-1:0]       path_mask, path_mask_n;

    logic                   changed;
    logic [NPROC-1:0]       cand;
    logic [NPROC-1:0]       seen;
    logic [NPROC-1:0]       higher;

    function automatic logic [IW-1:0] lowest(input logic [NPROC-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    // Graph helpers: successors of the current process and untried origins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        changed = (mon.proc_blocked != snap_blk) || (mon.dep_matrix != snap_dep);
        cand    = snap_dep[int'(cur)*NPROC +: NPROC] & snap_blk;
        seen    = visited | (ONE << cur);
        higher  = '0;
        for (int i = 0; i < NPROC; i++) begin
            higher[i] = snap_blk[i] && (i > int'(origin));
        end
    end

    // Next-state and datapath update for the settle/walk/report sequence.
    always_comb begin
        state_n      = state;
        snap_blk_n   = snap_blk;
        snap_dep_n   = snap_dep;
        settle_cnt_n = settle_cnt;
        origin_n     = origin;
        cur_n        = cur;
        visited_n    = visited;
        det_n        = det;
        org_oh_n     = org_oh;
        path_mask_n  = path_mask;
        case (state)
            IDLE: begin
                if (mon.proc_blocked != '0) begin
                    state_n      = SETTLE;
                    snap_blk_n   = mon.proc_blocked;
                    snap_dep_n   = mon.dep_matrix;
                    settle_cnt_n = '0;
                end
            end
            SETTLE: begin
                if (mon.proc_blocked == '0) begin
                    state_n = IDLE;
                end else if (changed) begin
                    snap_blk_n   = mon.proc_blocked;
                    snap_dep_n   = mon.dep_matrix;
                    settle_cnt_n = '0;
                end else if (settle_cnt == 8'(STABLE_CYCLES - 1)) begin
                    origin_n  = lowest(snap_blk);
                    cur_n     = lowest(snap_blk);
                    visited_n = '0;
                    state_n   = WALK;
                end else begin
                    settle_cnt_n = settle_cnt + 8'd1;
                end
            end
            WALK: begin
                if (cand != '0) begin
                    if (seen[lowest(cand)]) begin
                        state_n     = REPORT;
                        det_n       = 1'b1;
                        org_oh_n    = ONE << origin;
                        path_mask_n = seen;
                    end else begin
                        visited_n = seen;
                        cur_n     = lowest(cand);
                    end
                end else if (higher != '0) begin
                    // Dead end: restart from the next blocked process.
                    origin_n  = lowest(higher);
                    cur_n     = lowest(higher);
                    visited_n = '0;
                end else begin
                    state_n = HOLDOFF;
                end
            end
            REPORT: begin
                if (mon.dl_clear) begin
                    state_n     = IDLE;
                    det_n       = 1'b0;
                    org_oh_n    = '0;
                    path_mask_n = '0;
                end
            end
            HOLDOFF: begin
                // A false alarm is only re-examined once the picture changes.
                if (changed) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: snapshots are plain registers, not memories, so they are cleared along with the rest.
            state      <= IDLE;
            snap_blk   <= '0;
            snap_dep   <= '0;
            settle_cnt <= '0;
            origin     <= '0;
            cur        <= '0;
            visited    <= '0;
            det        <= 1'b0;
            org_oh     <= '0;
            path_mask  <= '0;
        end else begin
            state      <= state_n;
            snap_blk   <= snap_blk_n;
            snap_dep   <= snap_dep_n;
            settle_cnt <= settle_cnt_n;
            origin     <= origin_n;
            cur        <= cur_n;
            visited    <= visited_n;
            det        <= det_n;
            org_oh     <= org_oh_n;
            path_mask  <= path_mask_n;
        end
    end

    assign mon.dl_detect = det;
    assign mon.dl_origin = org_oh;
    assign mon.dl_path   = path_mask;
    assign mon.busy      = (state != IDLE);

`ifdef AESL_DEADLOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0]          tmo_cnt, tmo_cnt_n;
    logic [NPROC-1:0]       prev_blk;
    logic [NPROC*NPROC-1:0] prev_dep;
    logic                   tmo_flag;

    // Saturating blocked-cycle counter; a changed cycle starts a fresh count.
    always_comb begin
        tmo_cnt_n = tmo_cnt;
        if (mon.proc_blocked == '0) begin
            tmo_cnt_n = '0;
        end else if ((mon.proc_blocked != prev_blk) || (mon.dep_matrix != prev_dep)) begin
            tmo_cnt_n = TW'(1);
        end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt_n = tmo_cnt + TW'(1);
        end
    end

    // Sticky timeout flag, acknowledged by dl_clear in any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt  <= '0;
            prev_blk <= '0;
            prev_dep <= '0;
            tmo_flag <= 1'b0;
        end else begin
            tmo_cnt  <= tmo_cnt_n;
            prev_blk <= mon.proc_blocked;
            prev_dep <= mon.dep_matrix;
            if (mon.dl_clear) begin
                tmo_flag <= 1'b0;
            end else if (tmo_cnt_n == TW'(TIMEOUT)) begin
                tmo_flag <= 1'b1;
            end
        end
    end

    assign mon.dl_timeout = tmo_flag;
`endif
endmodule

// File: tb/tb_aesl_deadlock_monitor.sv
// Self-checking bench for aesl_deadlock_monitor: directed scenarios plus a
// randomized phase, all compared every cycle against a behavioural model
// that evaluates the wait-for graph as a whole.
module tb_aesl_deadlock_monitor;
    localparam int N  = 4;
    localparam int S  = 4;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    aesl_deadlock_monitor_if #(.NPROC(N)) mon ();

    aesl_deadlock_monitor #(
        .NPROC(N), .STABLE_CYCLES(S), .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mon  (mon)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [N*N-1:0] e(input int i, input int j);
        logic [N*N-1:0] v;
        v = '0;
        v[i*N+j] = 1'b1;
        return v;
    endfunction

    // Whole-graph evaluation: try each blocked origin in ascending order,
    // follow the lowest blocked successor, stop at a revisit or a dead end.
    // steps is the number of single-process visits across all walks.
    function automatic void analyze(input logic [N-1:0] blk, input logic [N*N-1:0] dep,
                                    output bit found, output logic [N-1:0] org,
                                    output logic [N-1:0] path, output int steps);
        bit seen [N];
        int cur;
        int nxt;
        bit done;
        found = 1'b0; org = '0; path = '0; steps = 0;
        for (int o = 0; o < N; o++) begin
            if (blk[o] && !found) begin
                foreach (seen[k]) seen[k] = 1'b0;
                cur  = o;
                done = 1'b0;
                for (int it = 0; it <= N && !done; it++) begin
                    steps++;
                    seen[cur] = 1'b1;
                    nxt = -1;
                    for (int j = N - 1; j >= 0; j--) begin
                        if (dep[cur*N+j] && blk[j]) nxt = j;
                    end
                    if (nxt < 0) begin
                        done = 1'b1;
                    end else if (seen[nxt]) begin
                        found = 1'b1;
                        org[o] = 1'b1;
                        foreach (seen[k]) path[k] = seen[k];
                        done = 1'b1;
                    end else begin
                        cur = nxt;
                    end
                end
            end
        end
    endfunction

    typedef enum {M_IDLE, M_SETTLE, M_WALK, M_REPORT, M_HOLD} mode_t;

    mode_t          m_mode = M_IDLE;
    logic [N-1:0]   m_sb   = '0;
    logic [N*N-1:0] m_sd   = '0;
    int             m_st   = 0;
    int             m_left = 0;
    bit             m_rf   = 1'b0;
    logic [N-1:0]   m_ro   = '0;
    logic [N-1:0]   m_rp   = '0;
    logic           m_det  = 1'b0;
    logic [N-1:0]   m_org  = '0;
    logic [N-1:0]   m_path = '0;
    int             m_tcnt = 0;
    logic [N-1:0]   m_pb   = '0;
    logic [N*N-1:0] m_pd   = '0;
    logic           m_tout = 1'b0;

    // Reference model, advanced on every rising edge.
    always @(posedge clock) begin : model
        mode_t          md;
        logic [N-1:0]   sb, ro, rp, org, path;
        logic [N*N-1:0] sd;
        int             st, left, stp, tc;
        bit             rf, chg, det, tout;
        md = m_mode; sb = m_sb; sd = m_sd; st = m_st; left = m_left;
        rf = m_rf; ro = m_ro; rp = m_rp; det = m_det; org = m_org; path = m_path;
        tc = m_tcnt; tout = m_tout;
        chg = (mon.proc_blocked != sb) || (mon.dep_matrix != sd);
        if (reset) begin
            md = M_IDLE; sb = '0; sd = '0; st = 0; left = 0;
            det = 1'b0; org = '0; path = '0; tc = 0; tout = 1'b0;
        end else begin
            case (md)
                M_IDLE: if (mon.proc_blocked != '0) begin
                    md = M_SETTLE; sb = mon.proc_blocked; sd = mon.dep_matrix; st = 0;
                end
                M_SETTLE: begin
                    if (mon.proc_blocked == '0) md = M_IDLE;
                    else if (chg) begin
                        sb = mon.proc_blocked; sd = mon.dep_matrix; st = 0;
                    end else if (st == S - 1) begin
                        analyze(sb, sd, rf, ro, rp, stp);
                        left = stp; md = M_WALK;
                    end else st++;
                end
                M_WALK: begin
                    if (left == 1) begin
                        if (rf) begin
                            md = M_REPORT; det = 1'b1; org = ro; path = rp;
                        end else md = M_HOLD;
                    end else left--;
                end
                M_REPORT: if (mon.dl_clear) begin
                    md = M_IDLE; det = 1'b0; org = '0; path = '0;
                end
                M_HOLD: if (chg) md = M_IDLE;
                default: md = M_IDLE;
            endcase
            if (mon.proc_blocked == '0) tc = 0;
            else if (mon.proc_blocked != m_pb || mon.dep_matrix != m_pd) tc = 1;
            else if (tc < TO) tc++;
            if (mon.dl_clear) tout = 1'b0;
            else if (tc == TO) tout = 1'b1;
        end
        m_mode <= md; m_sb <= sb; m_sd <= sd; m_st <= st; m_left <= left;
        m_rf <= rf; m_ro <= ro; m_rp <= rp; m_det <= det; m_org <= org; m_path <= path;
        m_tcnt <= tc; m_tout <= tout;
        m_pb <= reset ? '0 : mon.proc_blocked;
        m_pd <= reset ? '0 : mon.dep_matrix;
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clock) begin
        if (chk_on) begin
            check("dl_detect", 32'(mon.dl_detect), 32'(m_det));
            check("dl_origin", 32'(mon.dl_origin), 32'(m_org));
            check("dl_path",   32'(mon.dl_path),   32'(m_path));
            check("busy",      32'(mon.busy),      32'(m_mode != M_IDLE));
`ifdef AESL_DEADLOCK_TIMEOUT_EN
            check("dl_timeout", 32'(mon.dl_timeout), 32'(m_tout));
`endif
        end
    end

    task automatic set_in(input logic [N-1:0] blk, input logic [N*N-1:0] dep);
        mon.proc_blocked = blk;
        mon.dep_matrix   = dep;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_clear();
        mon.dl_clear = 1'b1;
        @(negedge clock);
        mon.dl_clear = 1'b0;
    endtask

    initial begin : stim
        bit           f;
        logic [N-1:0] ro, rp;
        int           stp;
        logic [N-1:0] rb;
        logic [N*N-1:0] rd;

        set_in('0, '0);
        mon.dl_clear = 1'b0;
        @(negedge clock);
        chk_on = 1'b1;
        check("reset_detect", 32'(mon.dl_detect), 32'd0);
        check("reset_busy",   32'(mon.busy),      32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Pin the model's graph evaluation on hand-worked cases.
        analyze(4'b0011, e(0,1) | e(1,0), f, ro, rp, stp);
        check("model_2cyc_found", 32'(f), 32'd1);
        check("model_2cyc_path",  32'(rp), 32'h3);
        check("model_2cyc_steps", 32'(stp), 32'd2);
        analyze(4'b0111, e(0,1) | e(1,2) | e(2,1), f, ro, rp, stp);
        check("model_tail_origin", 32'(ro), 32'h1);
        check("model_tail_path",   32'(rp), 32'h7);
        analyze(4'b0011, e(0,1) | e(1,3), f, ro, rp, stp);
        check("model_nocyc_found", 32'(f), 32'd0);
        check("model_nocyc_steps", 32'(stp), 32'd3);

        // Two-process cycle: detect S+3 cycles after capture.
        @(negedge clock);
        set_in(4'b0011, e(0,1) | e(1,0));
        wait_neg(S + 2);
        check("dl2_early", 32'(mon.dl_detect), 32'd0);
        wait_neg(1);
        check("dl2_detect", 32'(mon.dl_detect), 32'd1);
        check("dl2_origin", 32'(mon.dl_origin), 32'h1);
        check("dl2_path",   32'(mon.dl_path),   32'h3);
        wait_neg(3);
        set_in(4'b1100, '0);            // ignored while reporting
        wait_neg(2);
        check("dl2_hold", 32'(mon.dl_detect), 32'd1);
        set_in(4'b0011, e(0,1) | e(1,0));
        pulse_clear();
        check("clr_detect", 32'(mon.dl_detect), 32'd0);
        check("clr_path",   32'(mon.dl_path),   32'h0);
        check("clr_busy",   32'(mon.busy),      32'd0);
        wait_neg(S + 3);
        check("redetect", 32'(mon.dl_detect), 32'd1);
        set_in('0, '0);
        pulse_clear();
        wait_neg(2);

        // Cycle reached through a tail.
        set_in(4'b0111, e(0,1) | e(1,2) | e(2,1));
        wait_neg(S + 4);
        check("tail_detect", 32'(mon.dl_detect), 32'd1);
        check("tail_origin", 32'(mon.dl_origin), 32'h1);
        check("tail_path",   32'(mon.dl_path),   32'h7);
        set_in('0, '0);
        pulse_clear();
        wait_neg(2);

        // No cycle: both walks fail, HOLDOFF until the inputs move.
        set_in(4'b0011, e(0,1) | e(1,3));
        wait_neg(S + 12);
        check("holdoff_detect", 32'(mon.dl_detect), 32'd0);
        check("holdoff_busy",   32'(mon.busy),      32'd1);
        pulse_clear();                   // no effect outside REPORT
        check("holdoff_clear_busy", 32'(mon.busy), 32'd1);
        set_in(4'b0001, e(0,1));
        wait_neg(1);
        check("holdoff_exit", 32'(mon.busy), 32'd0);
        set_in('0, '0);
        wait_neg(2);

        // Unstable inputs never let a walk start.
        for (int t = 0; t < 12; t++) begin
            set_in((t % 2) ? 4'b0001 : 4'b0011, e(0,1) | e(1,0));
            wait_neg(2);
        end
        check("toggle_detect", 32'(mon.dl_detect), 32'd0);
        check("toggle_busy",   32'(mon.busy),      32'd1);
        set_in('0, '0);
        wait_neg(2);

        // Reset in the middle of a long walk aborts it.
        set_in(4'b1111, e(0,1) | e(1,2) | e(2,3));
        wait_neg(S + 3);
        reset = 1'b1;
        wait_neg(1);
        reset = 1'b0;
        check("rst_walk_detect", 32'(mon.dl_detect), 32'd0);
        check("rst_walk_busy",   32'(mon.busy),      32'd0);
        check("rst_walk_path",   32'(mon.dl_path),   32'h0);
        set_in('0, '0);
        wait_neg(S + 12);

`ifdef AESL_DEADLOCK_TIMEOUT_EN
        // Single blocked process with no cycle trips the timeout.
        set_in(4'b0001, '0);
        wait_neg(TO - 1);
        check("tmo_early", 32'(mon.dl_timeout), 32'd0);
        wait_neg(1);
        check("tmo_set",    32'(mon.dl_timeout), 32'd1);
        check("tmo_detect", 32'(mon.dl_detect),  32'd0);
        set_in('0, '0);
        wait_neg(2);
        check("tmo_sticky", 32'(mon.dl_timeout), 32'd1);
        pulse_clear();
        check("tmo_clear", 32'(mon.dl_timeout), 32'd0);
        wait_neg(2);
`endif

        // Randomized phase checked by the per-cycle model compare.
        for (int it = 0; it < 400; it++) begin
            rb = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            rd = '0;
            for (int b = 0; b < N * N; b++) begin
                if ($urandom_range(0, 3) == 0) rd[b] = 1'b1;
            end
            set_in(rb, rd);
            for (int c = $urandom_range(1, 16); c > 0; c--) begin
                mon.dl_clear = ($urandom_range(0, 4) == 0);
                reset = ($urandom_range(0, 150) == 0);
                @(negedge clock);
            end
            mon.dl_clear = 1'b0;
            reset = 1'b0;
        end
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
